// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: read-side consumer of an async FIFO.
// Prefetches FIFO words into a small circular buffer and presents them on a
// valid/ready stream, so FIFO read latency is hidden from consumer stalls.
// Everything runs on FIFO_r_clk; reset is asynchronous, active low.
module fifo_read_drainer #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 4,   // 2..8; at least 3 sustains 1 word/cycle
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  FIFO_r_clk,
    input  logic                  FIFO_r_reset_n,
    input  logic                  enable,
    input  logic                  FIFO_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  FIFO_r_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  idle
);

    localparam int PTR_W    = $clog2(BUF_DEPTH);
    localparam int CNT_BITS = $clog2(BUF_DEPTH + 1);
    // One extra bit so count + inflight cannot wrap before the compare.
    localparam int OCC_W    = CNT_BITS + 1;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_BITS-1:0]   count;
    logic                  inflight;
    logic [OCC_W-1:0]      occupancy;
    logic                  capture;
    logic                  pop;

    // Circular pointer advance; explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Read issue uses only registered state plus enable/FIFO_empty: an
    // in-flight read reserves a slot, and a same-cycle pop earns no credit,
    // so there is no combinational path from m_ready to FIFO_r_en.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight);
    assign FIFO_r_en = enable & ~FIFO_empty & (occupancy < DEPTH_OCC) & (state != DRAIN);

    // The word for the read accepted last edge is on fifo_rd_data now.
    assign capture = inflight;

    assign m_valid = (count != '0);
    assign pop     = m_valid & m_ready;
    assign m_data  = buf_mem[rd_ptr];
    assign idle    = (state == IDLE);

    // State register.
    always_ff @(posedge FIFO_r_clk or negedge FIFO_r_reset_n) begin
        if (!FIFO_r_reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignment for every registered value so all
            // flops update together at the edge, independent of block order.
            state <= state_next;
        end
    end

    // Next-state logic: DRAIN stops new reads but lets the buffer empty.
    always_comb begin
        // NOTE: default first so every path assigns state_next; no latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable) state_next = ((count != '0) || inflight) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (enable)                          state_next = RUN;
                else if ((count == '0) && !inflight) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointers, occupancy, read-in-flight flag and delivered-word counter.
    always_ff @(posedge FIFO_r_clk or negedge FIFO_r_reset_n) begin
        if (!FIFO_r_reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            words_out <= '0;
        end else begin
            // Clearing inflight on reset drops the word returning afterwards.
            inflight <= FIFO_r_en;
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                words_out <= words_out + CNT_WIDTH'(1);
            end
            case ({capture, pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    // Prefetch storage, written at the capture edge.
    always_ff @(posedge FIFO_r_clk or negedge FIFO_r_reset_n) begin
        if (!FIFO_r_reset_n) begin
            // NOTE: this tiny register buffer is reset so m_data reads 0 out
            // of reset; a large RAM-style store would normally be left unreset.
            for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
        end else if (capture) begin
            buf_mem[wr_ptr] <= fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_read_drainer.sv
// Testbench for fifo_read_drainer: three instances (default, BUF_DEPTH=3,
// CNT_WIDTH=4), each fed by its own behavioural FIFO with one-cycle read data.
module tb_fifo_read_drainer;

    localparam int DW = 16;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic enable      = 1'b0;
    logic m_ready     = 1'b0;
    logic force_empty = 1'b0;
    logic fifo_flush  = 1'b0;

    logic [2:0]         fifo_empty_v;
    logic [2:0]         r_en_v;
    logic [2:0]         m_valid_v;
    logic [2:0]         idle_v;
    logic [2:0][DW-1:0] rd_data_v;
    logic [2:0][DW-1:0] m_data_v;
    logic [2:0][DW-1:0] words_v;
    logic [3:0]         words_c4;

    logic [DW-1:0] fifo_mem [3][64];
    int            rd_idx [3];
    int            wr_idx [3];
    logic [DW-1:0] got_data [64];

    int n_cmp = 0;
    int n_err = 0;
    int ren_viol;
    int ren_high;
    int occ_viol;
    int got;
    int stable_err;

    typedef struct {
        logic          en;
        logic          rdy;
        logic          exp_ren;
        logic          exp_valid;
        logic          chk_data;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] exp_words;
        logic          exp_idle;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    fifo_read_drainer #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(16)) dut0 (
        .FIFO_r_clk(clk), .FIFO_r_reset_n(rst_n), .enable(enable),
        .FIFO_empty(fifo_empty_v[0]), .fifo_rd_data(rd_data_v[0]),
        .FIFO_r_en(r_en_v[0]), .m_data(m_data_v[0]), .m_valid(m_valid_v[0]),
        .m_ready(m_ready), .words_out(words_v[0]), .idle(idle_v[0]));

    fifo_read_drainer #(.DATA_WIDTH(DW), .BUF_DEPTH(3), .CNT_WIDTH(16)) dut1 (
        .FIFO_r_clk(clk), .FIFO_r_reset_n(rst_n), .enable(enable),
        .FIFO_empty(fifo_empty_v[1]), .fifo_rd_data(rd_data_v[1]),
        .FIFO_r_en(r_en_v[1]), .m_data(m_data_v[1]), .m_valid(m_valid_v[1]),
        .m_ready(m_ready), .words_out(words_v[1]), .idle(idle_v[1]));

    fifo_read_drainer #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(4)) dut2 (
        .FIFO_r_clk(clk), .FIFO_r_reset_n(rst_n), .enable(enable),
        .FIFO_empty(fifo_empty_v[2]), .fifo_rd_data(rd_data_v[2]),
        .FIFO_r_en(r_en_v[2]), .m_data(m_data_v[2]), .m_valid(m_valid_v[2]),
        .m_ready(m_ready), .words_out(words_c4), .idle(idle_v[2]));

    assign words_v[2] = {12'd0, words_c4};

    // FIFO empty flags: real occupancy, optionally forced empty.
    always_comb begin
        for (int i = 0; i < 3; i++) fifo_empty_v[i] = (rd_idx[i] == wr_idx[i]) || force_empty;
    end

    // FIFO read side: data for a read accepted at an edge appears after it.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fifo_flush) begin
                rd_idx[i] <= 0;
            end else if (r_en_v[i] && !fifo_empty_v[i]) begin
                rd_data_v[i] <= fifo_mem[i][rd_idx[i]];
                rd_idx[i]    <= rd_idx[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input logic [DW-1:0] base, input logic [DW-1:0] step,
                                          input int k);
        return base + step * DW'(k);
    endfunction

    function automatic vec_t mk(input logic en, input logic rdy, input logic ren, input logic vld,
                                input logic chk, input logic [DW-1:0] d, input logic [DW-1:0] w,
                                input logic idl);
        vec_t v;
        v.en = en; v.rdy = rdy; v.exp_ren = ren; v.exp_valid = vld;
        v.chk_data = chk; v.exp_data = d; v.exp_words = w; v.exp_idle = idl;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; force_empty = 1'b0; fifo_flush = 1'b1;
        for (int i = 0; i < 3; i++) wr_idx[i] = 0;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input int i, input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
        for (int k = 0; k < n; k++) fifo_mem[i][k] = word(base, step, k);
        wr_idx[i] = n;
    endtask

    // Run instance i until n words are seen on its stream or the bound expires.
    task automatic collect(input int i, input int n, input int bound, input bit rand_rdy,
                           input bit tog_empty, output int cnt);
        cnt = 0; ren_viol = 0; ren_high = 0; occ_viol = 0;
        for (int c = 0; c < bound && cnt < n; c++) begin
            @(negedge clk);
            m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tog_empty) force_empty = ((c / 3) % 2) == 1;
            #1;
            if (r_en_v[i] && fifo_empty_v[i]) ren_viol++;
            if (r_en_v[i]) ren_high++;
            if (32'(dut1.count) + 32'(dut1.inflight) > 3) occ_viol++;
            if (m_valid_v[i] && m_ready) begin
                got_data[cnt] = m_data_v[i];
                cnt++;
            end
        end
        force_empty = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle table for the streaming run: 8 words, m_ready held high.
        tbl[0]  = mk(1, 1, 1, 0, 0, 16'h0000, 16'd0, 1);
        tbl[1]  = mk(1, 1, 1, 0, 0, 16'h0000, 16'd0, 0);
        tbl[2]  = mk(1, 1, 1, 1, 1, 16'h1111, 16'd0, 0);
        tbl[3]  = mk(1, 1, 1, 1, 1, 16'h2222, 16'd1, 0);
        tbl[4]  = mk(1, 1, 1, 1, 1, 16'h3333, 16'd2, 0);
        tbl[5]  = mk(1, 1, 1, 1, 1, 16'h4444, 16'd3, 0);
        tbl[6]  = mk(1, 1, 1, 1, 1, 16'h5555, 16'd4, 0);
        tbl[7]  = mk(1, 1, 1, 1, 1, 16'h6666, 16'd5, 0);
        tbl[8]  = mk(1, 1, 0, 1, 1, 16'h7777, 16'd6, 0);
        tbl[9]  = mk(1, 1, 0, 1, 1, 16'h8888, 16'd7, 0);
        tbl[10] = mk(0, 1, 0, 0, 0, 16'h0000, 16'd8, 0);
        tbl[11] = mk(0, 1, 0, 0, 0, 16'h0000, 16'd8, 1);

        // Reset state.
        do_reset();
        #1;
        check("rst_ren",   32'(r_en_v[0]),    32'd0);
        check("rst_valid", 32'(m_valid_v[0]), 32'd0);
        check("rst_data",  32'(m_data_v[0]),  32'd0);
        check("rst_words", 32'(words_v[0]),   32'd0);
        check("rst_idle",  32'(idle_v[0]),    32'd1);

        // Test 1: streaming, table-driven.
        load(0, 8, 16'h1111, 16'h1111);
        release_reset();
        for (int k = 0; k < 12; k++) begin
            enable  = tbl[k].en;
            m_ready = tbl[k].rdy;
            #1;
            check($sformatf("t1_r%0d_ren", k),   32'(r_en_v[0]),    32'(tbl[k].exp_ren));
            check($sformatf("t1_r%0d_valid", k), 32'(m_valid_v[0]), 32'(tbl[k].exp_valid));
            if (tbl[k].chk_data)
                check($sformatf("t1_r%0d_data", k), 32'(m_data_v[0]), 32'(tbl[k].exp_data));
            check($sformatf("t1_r%0d_words", k), 32'(words_v[0]),   32'(tbl[k].exp_words));
            check($sformatf("t1_r%0d_idle", k),  32'(idle_v[0]),    32'(tbl[k].exp_idle));
            @(negedge clk);
        end

        // Test 2: stall fills the buffer after exactly 4 reads, data held.
        do_reset();
        load(0, 10, 16'h1111, 16'h1111);
        release_reset();
        enable = 1'b1; m_ready = 1'b0;
        stable_err = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (m_valid_v[0] && (m_data_v[0] !== 16'h1111)) stable_err++;
        end
        check("t2_reads",    32'(rd_idx[0]),     32'd4);
        check("t2_ren_off",  32'(r_en_v[0]),     32'd0);
        check("t2_count",    32'(dut0.count),    32'd4);
        check("t2_valid",    32'(m_valid_v[0]),  32'd1);
        check("t2_data",     32'(m_data_v[0]),   32'h1111);
        check("t2_unstable", 32'(stable_err),    32'd0);
        collect(0, 10, 100, 1'b0, 1'b0, got);
        check("t2_got", 32'(got), 32'd10);
        for (int k = 0; k < 10; k++)
            check($sformatf("t2_w%0d", k), 32'(got_data[k]), 32'(word(16'h1111, 16'h1111, k)));
        repeat (2) @(negedge clk);
        #1;
        check("t2_words", 32'(words_v[0]), 32'd10);

        // Test 3: drop enable with 2 buffered and 1 in flight.
        do_reset();
        load(0, 6, 16'h1111, 16'h1111);
        release_reset();
        enable = 1'b1; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        #1;
        check("t3_ren_off", 32'(r_en_v[0]), 32'd0);
        @(negedge clk);
        #1;
        check("t3_state_drain", 32'(dut0.state), 32'd2);
        check("t3_not_idle",    32'(idle_v[0]),  32'd0);
        collect(0, 3, 30, 1'b0, 1'b0, got);
        check("t3_got",      32'(got),      32'd3);
        check("t3_ren_high", 32'(ren_high), 32'd0);
        for (int k = 0; k < 3; k++)
            check($sformatf("t3_w%0d", k), 32'(got_data[k]), 32'(word(16'h1111, 16'h1111, k)));
        repeat (3) @(negedge clk);
        #1;
        check("t3_idle",  32'(idle_v[0]),    32'd1);
        check("t3_words", 32'(words_v[0]),   32'd3);
        check("t3_reads", 32'(rd_idx[0]),    32'd3);
        check("t3_valid", 32'(m_valid_v[0]), 32'd0);

        // Test 4: BUF_DEPTH=3, toggling FIFO_empty, random m_ready.
        do_reset();
        load(1, 20, 16'h4000, 16'h0101);
        release_reset();
        enable = 1'b1;
        collect(1, 20, 400, 1'b1, 1'b1, got);
        check("t4_got",      32'(got),      32'd20);
        check("t4_ren_empty", 32'(ren_viol), 32'd0);
        check("t4_occupancy", 32'(occ_viol), 32'd0);
        for (int k = 0; k < 20; k++)
            check($sformatf("t4_w%0d", k), 32'(got_data[k]), 32'(word(16'h4000, 16'h0101, k)));
        repeat (2) @(negedge clk);
        #1;
        check("t4_words", 32'(words_v[1]), 32'd20);

        // Test 5: asynchronous reset with count=3 and a read in flight.
        do_reset();
        load(0, 8, 16'h1111, 16'h1111);
        release_reset();
        enable = 1'b1; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        check("t5_pre_count",    32'(dut0.count),    32'd3);
        check("t5_pre_inflight", 32'(dut0.inflight), 32'd1);
        check("t5_pre_valid",    32'(m_valid_v[0]),  32'd1);
        rst_n = 1'b0; enable = 1'b0;
        #1;
        check("t5_rst_valid", 32'(m_valid_v[0]), 32'd0);
        check("t5_rst_ren",   32'(r_en_v[0]),    32'd0);
        check("t5_rst_data",  32'(m_data_v[0]),  32'd0);
        check("t5_rst_words", 32'(words_v[0]),   32'd0);
        check("t5_rst_idle",  32'(idle_v[0]),    32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t5_post_valid", 32'(m_valid_v[0]), 32'd0);
        check("t5_post_words", 32'(words_v[0]),   32'd0);
        enable = 1'b1;
        collect(0, 1, 20, 1'b0, 1'b0, got);
        check("t5_got",   32'(got),         32'd1);
        check("t5_first", 32'(got_data[0]), 32'h5555);

        // Test 6: 4-bit delivered counter wraps after 16 words.
        do_reset();
        load(2, 17, 16'h6000, 16'h0001);
        release_reset();
        enable = 1'b1;
        collect(2, 17, 200, 1'b0, 1'b0, got);
        check("t6_got",  32'(got),          32'd17);
        check("t6_last", 32'(got_data[16]), 32'h6010);
        repeat (2) @(negedge clk);
        #1;
        check("t6_words", 32'(words_v[2]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
